// File: rtl/gui_brush_ctrl.sv
// Brush-settings controller: button edges become pending color/width requests, committed atomically at the blanking boundary.
// Optional per-button auto-repeat is enabled by defining GUI_AUTO_REPEAT_EN.
module gui_brush_ctrl #(
    parameter int unsigned NUM_COLORS    = 9,
    parameter int unsigned MIN_WIDTH     = 1,
    parameter int unsigned MAX_WIDTH     = 7,
    parameter int unsigned DEFAULT_COLOR = 1,
    parameter int unsigned DEFAULT_WIDTH = 2,
    parameter int unsigned V_ACTIVE      = 720,
    parameter int unsigned REPEAT_DELAY  = 30,
    parameter int unsigned REPEAT_RATE   = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        color_next_in,
    input  logic        color_prev_in,
    input  logic        width_up_in,
    input  logic        width_down_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [3:0]  cursor_color_out,
    output logic [2:0]  stroke_width_out,
    output logic        update_out
);

    localparam int unsigned NBTN    = 4;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned WIDTH_W = 3;
    localparam int unsigned BTN_CN  = 0;
    localparam int unsigned BTN_CP  = 1;
    localparam int unsigned BTN_WU  = 2;
    localparam int unsigned BTN_WD  = 3;

    if (NUM_COLORS < 2 || NUM_COLORS > 16 || MAX_WIDTH > 7 || MIN_WIDTH > MAX_WIDTH ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("gui_brush_ctrl: illegal parameter combination");
    end

    logic [NBTN-1:0]    btn_lvl;
    logic [NBTN-1:0]    btn_rise;
    logic [NBTN-1:0]    rpt_set;
    logic [NBTN-1:0]    prev_q;
    logic [NBTN-1:0]    pend_q, pend_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               update_q, update_d;
    logic               boundary;

    assign btn_lvl  = {width_down_in, width_up_in, color_prev_in, color_next_in};
    assign btn_rise = btn_lvl & ~prev_q;
    assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

`ifdef GUI_AUTO_REPEAT_EN
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    rpt_state_e       rpt_q [NBTN];
    rpt_state_e       rpt_d [NBTN];
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NBTN; i++) begin
                rpt_q[i] <= RPT_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                rpt_q[i] <= rpt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Frame counters advance only at boundaries while the button stays held
    always_comb begin
        rpt_set = '0;
        for (int i = 0; i < NBTN; i++) begin
            rpt_d[i] = rpt_q[i];
            cnt_d[i] = cnt_q[i];
            case (rpt_q[i])
                RPT_IDLE: begin
                    if (btn_rise[i]) begin
                        rpt_d[i] = RPT_DELAY;
                        cnt_d[i] = '0;
                    end
                end
                RPT_DELAY: begin
                    if (!btn_lvl[i]) begin
                        rpt_d[i] = RPT_IDLE;
                    end else if (boundary) begin
                        if (CNT_W'(cnt_q[i] + CNT_W'(1)) == CNT_W'(REPEAT_DELAY)) begin
                            rpt_d[i]   = RPT_REPEAT;
                            cnt_d[i]   = '0;
                            rpt_set[i] = 1'b1;
                        end else begin
                            cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
                        end
                    end
                end
                RPT_REPEAT: begin
                    if (!btn_lvl[i]) begin
                        rpt_d[i] = RPT_IDLE;
                    end else if (boundary) begin
                        if (CNT_W'(cnt_q[i] + CNT_W'(1)) == CNT_W'(REPEAT_RATE)) begin
                            cnt_d[i]   = '0;
                            rpt_set[i] = 1'b1;
                        end else begin
                            cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
                        end
                    end
                end
                default: begin
                    rpt_d[i] = RPT_IDLE;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end
`else
    assign rpt_set = '0;
`endif

    // Commit at the boundary; edges in the boundary cycle survive the clear
    always_comb begin
        pend_d   = pend_q;
        color_d  = color_q;
        width_d  = width_q;
        update_d = 1'b0;
        if (boundary) begin
            pend_d = '0;
            if (pend_q[BTN_CN] && !pend_q[BTN_CP]) begin
                color_d = (color_q == COLOR_W'(NUM_COLORS - 1)) ? '0 : COLOR_W'(color_q + COLOR_W'(1));
            end else if (pend_q[BTN_CP] && !pend_q[BTN_CN]) begin
                color_d = (color_q == '0) ? COLOR_W'(NUM_COLORS - 1) : COLOR_W'(color_q - COLOR_W'(1));
            end
            if (pend_q[BTN_WU] && !pend_q[BTN_WD]) begin
                width_d = (width_q >= WIDTH_W'(MAX_WIDTH)) ? width_q : WIDTH_W'(width_q + WIDTH_W'(1));
            end else if (pend_q[BTN_WD] && !pend_q[BTN_WU]) begin
                width_d = (width_q <= WIDTH_W'(MIN_WIDTH)) ? width_q : WIDTH_W'(width_q - WIDTH_W'(1));
            end
            update_d = (color_d != color_q) || (width_d != width_q);
        end
        pend_d = pend_d | btn_rise | rpt_set;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_q   <= '1;
            pend_q   <= '0;
            color_q  <= COLOR_W'(DEFAULT_COLOR);
            width_q  <= WIDTH_W'(DEFAULT_WIDTH);
            update_q <= 1'b0;
        end else begin
            prev_q   <= btn_lvl;
            pend_q   <= pend_d;
            color_q  <= color_d;
            width_q  <= width_d;
            update_q <= update_d;
        end
    end

    assign cursor_color_out = color_q;
    assign stroke_width_out = width_q;
    assign update_out       = update_q;

endmodule

// File: tb/tb_gui_brush_ctrl.sv
// Directed bench for gui_brush_ctrl: vector table of per-frame requests plus hand-written boundary/reset/hold sequences.
module tb_gui_brush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cn, cp, wu, wd;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [3:0]  color_o;
    logic [2:0]  width_o;
    logic        update_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gui_brush_ctrl dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .color_next_in    (cn),
        .color_prev_in    (cp),
        .width_up_in      (wu),
        .width_down_in    (wd),
        .hcount_in        (hc),
        .vcount_in        (vc),
        .cursor_color_out (color_o),
        .stroke_width_out (width_o),
        .update_out       (update_o)
    );

    typedef struct {
        logic [3:0] mask;   // {wd, wu, cp, cn}
        int         pulses;
        int         color;
        int         width;
        int         upd;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_frame(input int n);
        hc = 11'd5;
        vc = 10'd100;
        repeat (n) tick();
    endtask

    task automatic set_btn(input logic [3:0] m);
        {wd, wu, cp, cn} = m;
    endtask

    task automatic boundary();
        hc = 11'd0;
        vc = 10'd720;
        tick();
        hc = 11'd5;
        vc = 10'd100;
    endtask

    task automatic pulse(input logic [3:0] m);
        set_btn(m);
        tick();
        set_btn(4'b0000);
        tick();
    endtask

    task automatic chk_out(input string name, input int c, input int w, input int u);
        chk({name, " color"}, int'(color_o), c);
        chk({name, " width"}, int'(width_o), w);
        chk({name, " update"}, int'(update_o), u);
    endtask

    initial begin
        int exp_c;
        int inc;

        vecs[0]  = '{4'b0001, 1, 2, 2, 1};
        vecs[1]  = '{4'b0001, 3, 3, 2, 1};
        vecs[2]  = '{4'b0000, 1, 3, 2, 0};
        vecs[3]  = '{4'b0010, 1, 2, 2, 1};
        vecs[4]  = '{4'b0010, 1, 1, 2, 1};
        vecs[5]  = '{4'b0010, 1, 0, 2, 1};
        vecs[6]  = '{4'b0010, 1, 8, 2, 1};
        vecs[7]  = '{4'b0001, 1, 0, 2, 1};
        vecs[8]  = '{4'b0011, 1, 0, 2, 0};
        vecs[9]  = '{4'b0100, 1, 0, 3, 1};
        vecs[10] = '{4'b0100, 2, 0, 4, 1};
        vecs[11] = '{4'b0100, 1, 0, 5, 1};
        vecs[12] = '{4'b0100, 1, 0, 6, 1};
        vecs[13] = '{4'b0100, 1, 0, 7, 1};
        vecs[14] = '{4'b0100, 1, 0, 7, 0};
        vecs[15] = '{4'b1000, 1, 0, 6, 1};
        vecs[16] = '{4'b1100, 1, 0, 6, 0};
        vecs[17] = '{4'b1101, 1, 1, 6, 1};
        vecs[18] = '{4'b1000, 1, 1, 5, 1};
        vecs[19] = '{4'b1000, 1, 1, 4, 1};
        vecs[20] = '{4'b1000, 1, 1, 3, 1};
        vecs[21] = '{4'b1000, 1, 1, 2, 1};
        vecs[22] = '{4'b1000, 1, 1, 1, 1};
        vecs[23] = '{4'b1000, 1, 1, 1, 0};
        vecs[24] = '{4'b1010, 1, 0, 1, 1};

        // Reset with color_next held: no edge may appear afterwards
        rst = 1'b1;
        set_btn(4'b0001);
        mid_frame(3);
        chk_out("in reset", 1, 2, 0);
        rst = 1'b0;
        tick();
        chk_out("after reset", 1, 2, 0);
        for (int f = 0; f < 3; f++) begin
            mid_frame(2);
            boundary();
            chk_out($sformatf("held-through-reset frame%0d", f), 1, 2, 0);
        end
        set_btn(4'b0000);
        mid_frame(2);

        for (int i = 0; i < NV; i++) begin
            mid_frame(2);
            for (int p = 0; p < vecs[i].pulses; p++) pulse(vecs[i].mask);
            chk($sformatf("vec%0d pre-boundary update", i), int'(update_o), 0);
            boundary();
            chk_out($sformatf("vec%0d", i), vecs[i].color, vecs[i].width, vecs[i].upd);
            tick();
            chk($sformatf("vec%0d pulse width", i), int'(update_o), 0);
        end

        // Edge in the boundary cycle itself waits for the next boundary
        hc = 11'd0;
        vc = 10'd720;
        cn = 1'b1;
        tick();
        chk_out("edge-at-boundary same", 0, 1, 0);
        cn = 1'b0;
        mid_frame(3);
        boundary();
        chk_out("edge-at-boundary next", 1, 1, 1);

        // Pending commits while a new edge in the same cycle is kept
        mid_frame(2);
        pulse(4'b0001);
        hc = 11'd0;
        vc = 10'd720;
        cp = 1'b1;
        tick();
        chk_out("set-wins commit", 2, 1, 1);
        cp = 1'b0;
        mid_frame(3);
        boundary();
        chk_out("set-wins next", 1, 1, 1);

        // Mid-frame reset discards pending requests
        mid_frame(2);
        pulse(4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("midframe reset", 1, 2, 0);
        mid_frame(2);
        boundary();
        chk_out("midframe reset boundary", 1, 2, 0);

        // Reset in the boundary cycle beats the commit
        mid_frame(2);
        pulse(4'b0100);
        hc = 11'd0;
        vc = 10'd720;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hc = 11'd5;
        vc = 10'd100;
        chk_out("reset at boundary", 1, 2, 0);
        mid_frame(2);
        boundary();
        chk_out("reset at boundary next", 1, 2, 0);

        // Hold color_next across 59 boundaries, then release
        exp_c = 1;
        mid_frame(2);
        cn = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            mid_frame(2);
            boundary();
            inc = (k == 1) ? 1 : 0;
`ifdef GUI_AUTO_REPEAT_EN
            if (k >= 31 && ((k - 31) % 6) == 0) inc = 1;
`endif
            if (inc != 0) exp_c = (exp_c + 1) % 9;
            chk_out($sformatf("hold boundary%0d", k), exp_c, 2, inc);
        end
        cn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid_frame(2);
            boundary();
`ifdef GUI_AUTO_REPEAT_EN
            chk_out($sformatf("released frame%0d", k), 7, 2, 0);
`else
            chk_out($sformatf("released frame%0d", k), 2, 2, 0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
